// File: rtl/dff_mem_arbiter.sv
// Two-client arbiter/sequencer for a 16-byte single-port DFF memory: IDLE -> ACCESS -> RESP.
// Define DFF_MEM_ARB_RR_EN for round-robin tie-break; otherwise client 0 has fixed priority.
module dff_mem_arbiter #(
  parameter int unsigned ADDR_BITS = 4,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 req_valid_0,
  input  logic                 req_valid_1,
  input  logic                 req_write_0,
  input  logic                 req_write_1,
  input  logic [ADDR_BITS-1:0] req_addr_0,
  input  logic [ADDR_BITS-1:0] req_addr_1,
  input  logic [DATA_BITS-1:0] req_wdata_0,
  input  logic [DATA_BITS-1:0] req_wdata_1,
  output logic                 req_ready_0,
  output logic                 req_ready_1,
  output logic                 rsp_valid_0,
  output logic                 rsp_valid_1,
  output logic [DATA_BITS-1:0] rsp_rdata,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  output logic                 mem_wr_en,
  output logic                 mem_r_en,
  input  logic [DATA_BITS-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e               state_q, state_d;
  logic                 id_q;
  logic                 wr_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] wdata_q;
  logic [DATA_BITS-1:0] rsp_hold_q;
  logic                 mem_wr_en_q;
  logic                 mem_r_en_q;

  logic                 grant_0, grant_1;
  logic                 handshake;
  logic                 sel_write;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [DATA_BITS-1:0] sel_wdata;
  logic [DATA_BITS-1:0] rsp_data_now;

`ifdef DFF_MEM_ARB_RR_EN
  logic last_grant_q;

  // On a tie the client that was not granted last wins.
  always_comb begin
    grant_0 = req_valid_0 & (~req_valid_1 | last_grant_q);
    grant_1 = req_valid_1 & ~grant_0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else if (handshake) begin
      last_grant_q <= req_ready_1;
    end
  end
`else
  always_comb begin
    grant_0 = req_valid_0;
    grant_1 = req_valid_1 & ~req_valid_0;
  end
`endif

  // Ready is gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    req_ready_0 = rst_n & ena & (state_q == StIdle) & grant_0;
    req_ready_1 = rst_n & ena & (state_q == StIdle) & grant_1;
    handshake   = req_ready_0 | req_ready_1;
    sel_write   = req_ready_1 ? req_write_1 : req_write_0;
    sel_addr    = req_ready_1 ? req_addr_1  : req_addr_0;
    sel_wdata   = req_ready_1 ? req_wdata_1 : req_wdata_0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (handshake) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    rsp_data_now = wr_q ? wdata_q : mem_rdata;
    rsp_valid_0  = (state_q == StResp) & ~id_q;
    rsp_valid_1  = (state_q == StResp) & id_q;
    // Outside RESP the last response stays visible.
    rsp_rdata    = (state_q == StResp) ? rsp_data_now : rsp_hold_q;
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
    mem_wr_en    = mem_wr_en_q;
    mem_r_en     = mem_r_en_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      id_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_hold_q  <= '0;
      mem_wr_en_q <= 1'b0;
      mem_r_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_wr_en_q <= handshake & sel_write;
      mem_r_en_q  <= handshake & ~sel_write;
      if (handshake) begin
        id_q    <= req_ready_1;
        wr_q    <= sel_write;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (state_q == StResp) begin
        rsp_hold_q <= rsp_data_now;
      end
    end
  end

endmodule

// File: tb/tb_dff_mem_arbiter.sv
// Directed bench for dff_mem_arbiter with a behavioural 16-byte memory and a response scoreboard.
module tb_dff_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic       req_valid_0, req_valid_1, req_write_0, req_write_1;
  logic [3:0] req_addr_0, req_addr_1;
  logic [7:0] req_wdata_0, req_wdata_1;
  logic       req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1;
  logic [7:0] rsp_rdata, mem_wdata, mem_rdata;
  logic [3:0] mem_addr;
  logic       mem_wr_en, mem_r_en;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         c;
    logic [7:0] d;
  } exp_t;
  exp_t       sb[$];
  logic [7:0] shadow[16];
  logic [7:0] mem[16];

  always #5 clk = ~clk;

  dff_mem_arbiter #(.ADDR_BITS(4), .DATA_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_write_0(req_write_0), .req_write_1(req_write_1),
    .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
    .req_wdata_0(req_wdata_0), .req_wdata_1(req_wdata_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_rdata(rsp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wr_en(mem_wr_en), .mem_r_en(mem_r_en), .mem_rdata(mem_rdata)
  );

  // Memory with registered read port.
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_r_en) mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_tests++;
      assert (!(mem_wr_en === 1'b1 && mem_r_en === 1'b1)) else begin
        n_fail++;
        $error("FAIL strobe_excl: wr_en=%b r_en=%b expected not both 1", mem_wr_en, mem_r_en);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int c, input logic wr, input logic [3:0] a, input logic [7:0] wd);
    if (c == 0) begin
      req_valid_0 = 1'b1; req_write_0 = wr; req_addr_0 = a; req_wdata_0 = wd;
    end else begin
      req_valid_1 = 1'b1; req_write_1 = wr; req_addr_1 = a; req_wdata_1 = wd;
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rdy0"}, {31'd0, req_ready_0}, 0);
    chk({tag, "_rdy1"}, {31'd0, req_ready_1}, 0);
    chk({tag, "_rsp0"}, {31'd0, rsp_valid_0}, 0);
    chk({tag, "_rsp1"}, {31'd0, rsp_valid_1}, 0);
    chk({tag, "_rdata"}, {24'd0, rsp_rdata}, 0);
    chk({tag, "_maddr"}, {28'd0, mem_addr}, 0);
    chk({tag, "_mwdata"}, {24'd0, mem_wdata}, 0);
    chk({tag, "_wr_en"}, {31'd0, mem_wr_en}, 0);
    chk({tag, "_r_en"}, {31'd0, mem_r_en}, 0);
  endtask

  // Waits for a grant, then follows it through ACCESS and RESP; returns at N+3 (posedge+1).
  task automatic serve(input int exp_c, input logic exp_wr, input logic [3:0] a,
                       input logic [7:0] wd, input bit drop, input bit ena_drop,
                       input int max_wait, output int waited);
    int         obs_c;
    exp_t       e;
    logic [7:0] held;
    waited = 0;
    #1;
    while (!(req_ready_0 || req_ready_1) && waited < max_wait) begin
      @(posedge clk); #1;
      waited++;
    end
    obs_c = (req_ready_0 && req_ready_1) ? 3 : req_ready_0 ? 0 : req_ready_1 ? 1 : 2;
    chk("grant", obs_c, exp_c);
    if (obs_c != 0 && obs_c != 1) return;
    e.c = exp_c;
    e.d = exp_wr ? wd : shadow[a];
    if (exp_wr) shadow[a] = wd;
    sb.push_back(e);
    @(posedge clk); #1;
    if (drop) begin
      if (exp_c == 0) req_valid_0 = 1'b0; else req_valid_1 = 1'b0;
    end
    if (ena_drop) ena = 1'b0;
    chk("access_wr_en", {31'd0, mem_wr_en}, {31'd0, exp_wr});
    chk("access_r_en", {31'd0, mem_r_en}, {31'd0, ~exp_wr});
    chk("access_addr", {28'd0, mem_addr}, {28'd0, a});
    if (exp_wr) chk("access_wdata", {24'd0, mem_wdata}, {24'd0, wd});
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("rsp_valid_own", {31'd0, (e.c == 0) ? rsp_valid_0 : rsp_valid_1}, 1);
    chk("rsp_valid_other", {31'd0, (e.c == 0) ? rsp_valid_1 : rsp_valid_0}, 0);
    chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.d});
    chk("resp_strobes", {30'd0, mem_wr_en, mem_r_en}, 0);
    held = e.d;
    @(posedge clk); #1;
    chk("rsp_idle", {30'd0, rsp_valid_0, rsp_valid_1}, 0);
    chk("rsp_hold", {24'd0, rsp_rdata}, {24'd0, held});
  endtask

  initial begin
    int w;
    int exp_c;
    rst_n = 1'b0; ena = 1'b1;
    req_valid_0 = 0; req_valid_1 = 0; req_write_0 = 0; req_write_1 = 0;
    req_addr_0 = 0; req_addr_1 = 0; req_wdata_0 = 0; req_wdata_1 = 0;
    for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
    @(posedge clk); @(posedge clk); #1;
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: client 0 writes A5 to addr 3
    set_req(0, 1'b1, 4'd3, 8'hA5);
    serve(0, 1'b1, 4'd3, 8'hA5, 1'b1, 1'b0, 0, w);

    // 2: client 1 reads addr 3
    set_req(1, 1'b0, 4'd3, 8'h00);
    serve(1, 1'b0, 4'd3, 8'h00, 1'b1, 1'b0, 0, w);

    // 3: both clients continuously requesting
    set_req(0, 1'b0, 4'd3, 8'h00);
    set_req(1, 1'b1, 4'd9, 8'h11);
    for (int t = 0; t < 6; t++) begin
`ifdef DFF_MEM_ARB_RR_EN
      exp_c = t % 2;
`else
      exp_c = 0;
`endif
      if (exp_c == 0) serve(0, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 0, w);
      else            serve(1, 1'b1, 4'd9, 8'h11, 1'b0, 1'b0, 0, w);
      chk("rr_spacing", w, 0);
    end
    req_valid_0 = 0; req_valid_1 = 0;
    @(posedge clk); #1;

    // 4: ena drops during ACCESS of a read of addr 7
    set_req(1, 1'b1, 4'd7, 8'h3C);
    serve(1, 1'b1, 4'd7, 8'h3C, 1'b1, 1'b0, 0, w);
    set_req(0, 1'b0, 4'd7, 8'h00);
    serve(0, 1'b0, 4'd7, 8'h00, 1'b0, 1'b1, 0, w);
    for (int i = 0; i < 3; i++) begin
      chk("ena_low_rdy0", {31'd0, req_ready_0}, 0);
      chk("ena_low_rdy1", {31'd0, req_ready_1}, 0);
      @(posedge clk); #1;
    end
    ena = 1'b1;
    serve(0, 1'b0, 4'd7, 8'h00, 1'b1, 1'b0, 0, w);

    // 5: reset in the ACCESS cycle of a client-1 read
    set_req(1, 1'b0, 4'd3, 8'h00);
    #1;
    chk("pre_rst_grant1", {31'd0, req_ready_1}, 1);
    @(posedge clk); #1;
    chk("pre_rst_r_en", {31'd0, mem_r_en}, 1);
    rst_n = 1'b0; req_valid_1 = 1'b0;
    @(posedge clk); #1;
    chk_outputs_zero("midrst");
    @(posedge clk); #1;
    chk("midrst_no_rsp1", {31'd0, rsp_valid_1}, 0);
    rst_n = 1'b1;
    set_req(0, 1'b0, 4'd7, 8'h00);
    set_req(1, 1'b0, 4'd3, 8'h00);
    serve(0, 1'b0, 4'd7, 8'h00, 1'b1, 1'b0, 0, w);
    req_valid_1 = 1'b0;
    @(posedge clk); #1;

    // 6: sweep write then read all addresses
    for (int k = 0; k < 16; k++) begin
      logic [7:0] v;
      v = 8'(k) ^ 8'h5A;
      set_req(k % 2, 1'b1, 4'(k), v);
      serve(k % 2, 1'b1, 4'(k), v, 1'b1, 1'b0, 4, w);
    end
    for (int k = 0; k < 16; k++) begin
      set_req((k + 1) % 2, 1'b0, 4'(k), 8'h00);
      serve((k + 1) % 2, 1'b0, 4'(k), 8'h00, 1'b1, 1'b0, 4, w);
    end
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
